// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

    // UNCFG: no pattern loaded, stream ignored.
    // FILL : fewer than len bits collected since the last (re)start.
    // RUN  : history holds at least len bits, every accepted bit is compared.
    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Width needed to hold a length in 0..pat_w inclusive.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Reset and clear win over increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= W'(sat_inc(32'(cnt), W));
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector with overlap control and a
// saturating match counter.
//
// Handshake: a stream bit is consumed on a rising edge where in_valid is 1,
// rst is 0, cfg_load is 0 and a pattern is loaded; there is no back-pressure.
// cfg_load consumes the configuration on its edge and drops any coincident bit.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed,
    output state_t           dbg_state
);

    logic [PAT_W-1:0] pat, pat_n;
    logic [LEN_W-1:0] len, len_n;
    logic             ovl, ovl_n;
    logic [PAT_W-1:0] hist, hist_n;
    logic [LEN_W-1:0] fill, fill_n;
    state_t           state, state_n;
    logic             match_n;

    logic             accept;
    logic             hit;
    logic             cnt_inc;
    logic             full_next;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] cand;
    logic [LEN_W:0]   fill_p1;
    logic [LEN_W-1:0] cfg_len_c;

    // Compare the incoming bit against the pattern and derive the next state.
    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        cand      = {hist[PAT_W-2:0], in_data} & mask;
        fill_p1   = {1'b0, fill} + (LEN_W+1)'(1);
        full_next = (fill_p1 >= {1'b0, len});
        accept    = in_valid && (state != UNCFG);
        hit       = accept && (cand == (pat & mask)) && full_next;
        cfg_len_c = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

        pat_n   = pat;
        len_n   = len;
        ovl_n   = ovl;
        hist_n  = hist;
        fill_n  = fill;
        state_n = state;
        match_n = 1'b0;
        cnt_inc = 1'b0;

        if (cfg_load) begin
            pat_n   = cfg_pattern;
            len_n   = cfg_len_c;
            ovl_n   = cfg_overlap;
            hist_n  = '0;
            fill_n  = '0;
            state_n = (cfg_len_c == '0) ? UNCFG : FILL;
        end else if (accept) begin
            match_n = hit;
            cnt_inc = hit;
            if (hit && !ovl) begin
                // The matching bit is consumed; the next match starts fresh.
                hist_n  = '0;
                fill_n  = '0;
                state_n = FILL;
            end else begin
                hist_n  = {hist[PAT_W-2:0], in_data};
                fill_n  = full_next ? len : fill_p1[LEN_W-1:0];
                state_n = full_next ? RUN : FILL;
            end
        end
    end

    // Register configuration, history, state and the match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat   <= '0;
            len   <= '0;
            ovl   <= 1'b0;
            hist  <= '0;
            fill  <= '0;
            state <= UNCFG;
            match <= 1'b0;
        end else begin
            pat   <= pat_n;
            len   <= len_n;
            ovl   <= ovl_n;
            hist  <= hist_n;
            fill  <= fill_n;
            state <= state_n;
            match <= match_n;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (cnt_inc),
        .cnt (match_count)
    );

    assign armed     = (state != UNCFG);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: reference model over a bit queue plus
// literal expectations at the key points of each scenario.
module tb_seq_detector_prog;
    import seq_det_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = 4;
    localparam int CNT_MAX = 3;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_data = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;
    state_t           dbg_state;

    always #5 clk = ~clk;

    seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .match       (match),
        .match_count (match_count),
        .armed       (armed),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the accepted bits since the last restart; a match is the tail of
    // that queue spelling the pattern, first-received bit = pat[len-1].
    logic exp_q[$];
    logic [PAT_W-1:0] m_pat = '0;
    int  m_len = 0;
    bit  m_ovl = 0;
    bit  m_cfg = 0;
    int  m_cnt = 0;
    bit  nxt_match = 0, exp_match = 0;
    int  nxt_cnt = 0, exp_cnt = 0;
    bit  nxt_armed = 0, exp_armed = 0;

    function automatic bit tail_matches();
        int n;
        n = exp_q.size();
        if (m_len == 0 || n < m_len) return 0;
        for (int i = 0; i < m_len; i++)
            if (exp_q[n-m_len+i] != m_pat[m_len-1-i]) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit r, input bit ld, input logic [PAT_W-1:0] p,
                              input int l, input bit o, input bit v, input bit d);
        bit h;
        nxt_match = 0;
        if (r) begin
            exp_q.delete(); m_pat = '0; m_len = 0; m_ovl = 0; m_cfg = 0; m_cnt = 0;
        end else if (ld) begin
            m_len = (l > PAT_W) ? PAT_W : l;
            m_pat = p; m_ovl = o; m_cfg = (m_len != 0); m_cnt = 0;
            exp_q.delete();
        end else if (v && m_cfg) begin
            exp_q.push_back(d);
            if (exp_q.size() > PAT_W) void'(exp_q.pop_front());
            h = tail_matches();
            nxt_match = h;
            if (h) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) exp_q.delete();
            end
        end
        nxt_cnt = m_cnt;
        nxt_armed = m_cfg;
    endtask

    always @(posedge clk) begin
        exp_match <= nxt_match;
        exp_cnt   <= nxt_cnt;
        exp_armed <= nxt_armed;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_match", int'(match), int'(exp_match));
            chk("cmp_count", int'(match_count), exp_cnt);
            chk("cmp_armed", int'(armed), int'(exp_armed));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit r, input bit ld, input logic [PAT_W-1:0] p,
                       input int l, input bit o, input bit v, input bit d);
        rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(l);
        cfg_overlap = o; in_valid = v; in_data = d;
        model_step(r, ld, p, l, o, v, d);
        @(posedge clk);
        #1;
        rst = 0; cfg_load = 0; in_valid = 0; in_data = 0;
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int l, input bit o);
        cyc(0, 1, p, l, o, 0, 0);
    endtask

    task automatic feed(input bit d, input bit lit);
        cyc(0, 0, '0, 0, 0, 1, d);
        chk("lit_match", int'(match), int'(lit));
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 0, 0, 0);
        chk("lit_idle", int'(match), 0);
    endtask

    task automatic feed_seq(input logic [15:0] bits, input logic [15:0] hits, input int n);
        for (int i = n - 1; i >= 0; i--) feed(bits[i], hits[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc(1, 0, '0, 0, 0, 0, 0);
        cyc(1, 0, '0, 0, 0, 1, 1);
        chk_en = 1;
        chk("rst_match", int'(match), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_armed", int'(armed), 0);

        // Overlap on: 1011 over 1011011 -> hits on bits 4 and 7.
        load(8'b1011, 4, 1);
        chk("ovl_armed", int'(armed), 1);
        feed_seq(16'b1011011, 16'b0001001, 7);
        chk("ovl_count", int'(match_count), 2);
        idle();

        // Overlap off: only the first hit.
        load(8'b1011, 4, 0);
        chk("novl_clr", int'(match_count), 0);
        feed_seq(16'b1011011, 16'b0001000, 7);
        chk("novl_count", int'(match_count), 1);

        // Gapped valid: 110 with idle cycles in between.
        load(8'b110, 3, 0);
        feed(1, 0); idle(); idle(); idle();
        feed(1, 0); idle();
        feed(0, 1);
        idle();
        chk("gap_count", int'(match_count), 1);

        // Reconfigure mid-stream; the coincident bit is dropped.
        feed_seq(16'b101, 16'b000, 3);
        cyc(0, 1, 8'b11, 2, 1, 1, 1);
        chk("recfg_count", int'(match_count), 0);
        chk("recfg_match", int'(match), 0);
        feed(1, 0);
        feed(1, 1);

        // Saturation: len 1, six ones -> six pulses, count sticks at 3.
        load(8'b1, 1, 1);
        feed_seq(16'b111111, 16'b111111, 6);
        chk("sat_count", int'(match_count), 3);
        feed(0, 0);

        // Clamp: cfg_len 15 behaves as 8.
        load(8'hA5, 15, 0);
        chk("clamp_armed", int'(armed), 1);
        feed_seq(16'b10100101, 16'b00000001, 8);
        chk("clamp_count", int'(match_count), 1);

        // Reset on the final pattern bit: no pulse, detector disarmed.
        load(8'b1011, 4, 1);
        feed_seq(16'b101, 16'b000, 3);
        cyc(1, 0, '0, 0, 0, 1, 1);
        chk("rstm_match", int'(match), 0);
        chk("rstm_count", int'(match_count), 0);
        chk("rstm_armed", int'(armed), 0);
        feed_seq(16'b1011, 16'b0000, 4);

        // Loading len 0 disarms.
        load(8'b1, 1, 1);
        feed(1, 1);
        load(8'b1, 0, 1);
        chk("len0_armed", int'(armed), 0);
        feed(1, 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial sequence detector, successor to the fixed-pattern Moore detector in lab13. It watches a 1-bit qualified serial stream for a configurable pattern of 1..PAT_W bits and emits a registered one-cycle match pulse. Overlapping and non-overlapping matching are selectable, and a saturating match counter is provided. It sits between a serial bit source and downstream status/LED logic in the lab top level.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2)
- CNT_W, 8: match counter width (≥1)
- LEN_W, derived = $clog2(PAT_W+1): width of length fields
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- in_valid  input  1  in_data carries a stream bit this cycle
- in_data  input  1  serial stream bit
- cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
- cfg_pattern  input  PAT_W  pattern; bit [len-1] is first received, bit [0] last
- cfg_len  input  LEN_W  pattern length
- cfg_overlap  input  1  1 = overlapping matches allowed
- match  output  1  one-cycle registered match pulse
- match_count  output  CNT_W  saturating count of matches
- armed  output  1  valid configuration loaded (state ≠ UNCFG)

## Operation
- Registers: pat, len, ovl (config); hist[PAT_W-1:0] shift history; fill (LEN_W, saturates at len); state; match; match_count.
- Shift on accepted bit: hist <= {hist[PAT_W-2:0], in_data}; fill <= min(fill+1, len).
- States: UNCFG (no config, stream ignored), FILL (fill < len), RUN (fill == len, compare active).
- Compare: on an accepted bit, candidate = {hist[len-2:0], in_data} masked to len bits; hit when candidate == pat[len-1:0] and fill+1 ≥ len.
- Hit → match <= 1, match_count <= match_count+1, saturating at 2^CNT_W−1.
- Hit with ovl=1: stay/enter RUN, history kept.
- Hit with ovl=0: fill <= 0, hist <= 0, next state FILL; the matching bit is not reused.
- Transitions: UNCFG→FILL on cfg_load with legal len; FILL→RUN when fill reaches len; RUN→FILL on non-overlap hit; any→UNCFG on cfg_load with cfg_len == 0.
- cfg_len > PAT_W: clamped to PAT_W at load.
- cfg_len == 1: every accepted bit equal to pat[0] matches.
- cfg_load: takes priority over a coincident in_valid, and that bit is dropped. It clears hist, fill, match and match_count, and loads the new config.
- in_valid low: no shift and no compare; state, hist and fill are held; match is 0.

## Timing
- Reset values: match=0, match_count=0, armed=0, state=UNCFG, pat=0, len=0, ovl=0, hist=0, fill=0.
- Latency: match is high exactly in the cycle after the clock edge that accepted the final pattern bit. It is high for one cycle only.
- match_count updates on the same edge that sets match.
- Back-to-back overlapping hits on consecutive valid bits produce consecutive match cycles.
- armed is 1 from the cycle after a legal cfg_load.
- rst asserted mid-stream: all state returns to reset values on that edge; the coincident bit is ignored. The detector then needs a new cfg_load before it detects again.
- rst has priority over cfg_load, which has priority over in_valid.

## Structure
- Package seq_det_pkg: state enum (UNCFG, FILL, RUN), a LEN_W helper function, and a shared saturating-increment function.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt). It is reused for match_count.
- Everything else is flat: one state register block, one next-state/compare combinational block, one output register.

## Test plan
- Overlap on: load pat=4'b1011, len=4, ovl=1; feed 1,0,1,1,0,1,1 → match after bits 4 and 7; match_count=2.
- Overlap off: same config with ovl=0, same stream → match after bit 4 only; match_count=1.
- Gapped valid: pat=3'b110, len=3; feed 1,(valid=0 ×3),1,(valid=0),0 → single match one cycle after the final 0.
- Reconfigure mid-stream: after feeding 1,0,1, load pat=2'b11, len=2 in the same cycle as valid bit 1 → that bit is dropped and count=0. Then feed 1,1 → match.
- Saturation and clamp: CNT_W=2, len=1, pat=1'b1; feed six 1s → six match pulses, match_count stuck at 3. Also: cfg_len=15 with PAT_W=8 → len reads back as 8 (match requires 8 bits).
- Reset mid-match: assert rst in the cycle the final pattern bit is valid → no match pulse, all outputs 0, armed=0. Later valid bits produce no match until a new cfg_load.
